// File: rtl/alu_operand_loader.sv
// Collects ALU operand A, operand B and a 4-bit select from one shared bus on successive
// load edges, then holds them under a valid/ack handshake. Define ALU_LOADER_SYNC_EN to
// pass load/ack/clear through 2-flop synchronizers.
module alu_operand_loader #(
    parameter int N = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] in,
    input  logic         load,
    input  logic         ack,
    input  logic         clear,
    output logic [N-1:0] a_out,
    output logic [N-1:0] b_out,
    output logic [3:0]   sel_out,
    output logic         valid,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        LOAD_A   = 2'd0,
        LOAD_B   = 2'd1,
        LOAD_SEL = 2'd2,
        READY    = 2'd3
    } state_t;

    state_t cur, nxt;
    logic   load_c, ack_c, clear_c;
    logic   load_q, ld_pulse;

`ifdef ALU_LOADER_SYNC_EN
    logic [1:0] load_sy, ack_sy, clear_sy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_sy  <= '0;
            ack_sy   <= '0;
            clear_sy <= '0;
        end else begin
            load_sy  <= {load_sy[0], load};
            ack_sy   <= {ack_sy[0], ack};
            clear_sy <= {clear_sy[0], clear};
        end
    end

    assign load_c  = load_sy[1];
    assign ack_c   = ack_sy[1];
    assign clear_c = clear_sy[1];
`else
    assign load_c  = load;
    assign ack_c   = ack;
    assign clear_c = clear;
`endif

    // One pulse per rising edge of load, however long it stays high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) load_q <= 1'b0;
        else        load_q <= load_c;
    end

    assign ld_pulse = load_c & ~load_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cur <= LOAD_A;
        else        cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        if (clear_c) begin
            nxt = LOAD_A;
        end else begin
            case (cur)
                LOAD_A:   if (ld_pulse) nxt = LOAD_B;
                LOAD_B:   if (ld_pulse) nxt = LOAD_SEL;
                LOAD_SEL: if (ld_pulse) nxt = READY;
                READY:    if (ack_c)    nxt = LOAD_A;
                default:  nxt = LOAD_A;
            endcase
        end
    end

    // Captured values survive the handshake; only clear or reset zeroes them.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_out   <= '0;
            b_out   <= '0;
            sel_out <= '0;
        end else if (clear_c) begin
            a_out   <= '0;
            b_out   <= '0;
            sel_out <= '0;
        end else if (ld_pulse) begin
            case (cur)
                LOAD_A:   a_out   <= in;
                LOAD_B:   b_out   <= in;
                LOAD_SEL: sel_out <= in[3:0];
                default:  ;
            endcase
        end
    end

    always_comb begin
        state = cur;
        valid = (cur == READY);
    end

endmodule
